// File: rtl/schmidl_cox_frame_ctrl.sv
// Schmidl-Cox frame-capture sequencer: threshold crossing, windowed peak search,
// offset skip, then one framed packet forwarded with zero-latency pass-through.
module schmidl_cox_frame_ctrl #(
    parameter int DATA_W   = 32,
    parameter int METRIC_W = 32,
    parameter int LEN_W    = 16,
    parameter int PEAK_WIN = 64
) (
    input  logic                ce_clk,
    input  logic                ce_rst,
    input  logic                cfg_enable,
    input  logic [METRIC_W-1:0] cfg_threshold,
    input  logic [LEN_W-1:0]    cfg_packet_size,
    input  logic [LEN_W-1:0]    cfg_offset,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [METRIC_W-1:0] s_metric,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic                m_tuser,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                det_pulse,
    output logic                det_late,
    output logic [METRIC_W-1:0] det_peak,
    output logic [31:0]         det_count
);

    localparam int WIN_W = (PEAK_WIN > 2) ? $clog2(PEAK_WIN) : 1;
    localparam logic [WIN_W-1:0]      WIN_LAST   = WIN_W'(PEAK_WIN - 32'sd1);
    localparam logic signed [LEN_W:0] WIN_LAST_L = (LEN_W+1)'(PEAK_WIN - 32'sd1);
    localparam logic signed [LEN_W:0] ONE_L      = (LEN_W+1)'(1'b1);
    localparam logic signed [LEN_W:0] ZERO_L     = {(LEN_W+1){1'b0}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        PEAK   = 2'd1,
        SKIP   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                state_r;
    logic [METRIC_W-1:0]   peak_val_r;
    logic [WIN_W-1:0]      peak_idx_r;
    logic [WIN_W-1:0]      win_cnt_r;
    logic [LEN_W:0]        skip_cnt_r;
    logic [LEN_W-1:0]      out_cnt_r;
    logic [LEN_W-1:0]      pkt_last_r;
    logic [LEN_W-1:0]      offset_r;

    logic                  accept_s;
    logic                  above_s;
    logic [METRIC_W-1:0]   peak_val_nxt_s;
    logic [WIN_W-1:0]      peak_idx_nxt_s;
    logic signed [LEN_W:0] idx_ext_s;
    logic signed [LEN_W:0] off_ext_s;
    logic signed [LEN_W:0] d_s;
    logic signed [LEN_W:0] skip_s;
    logic                  late_s;

    assign accept_s       = s_tvalid && s_tready;
    assign above_s        = s_metric > peak_val_r;
    assign peak_val_nxt_s = above_s ? s_metric : peak_val_r;
    assign peak_idx_nxt_s = above_s ? win_cnt_r : peak_idx_r;
    // Distance from the final peak to the window end decides skip length or lateness.
    assign idx_ext_s      = {{(LEN_W+1-WIN_W){1'b0}}, peak_idx_nxt_s};
    assign off_ext_s      = {1'b0, offset_r};
    assign d_s            = WIN_LAST_L - idx_ext_s;
    assign skip_s         = off_ext_s - d_s - ONE_L;
    assign late_s         = (off_ext_s <= d_s);

    // Stream handshake and pass-through; everything is quiet while reset is held.
    always_comb begin
        s_tready = 1'b0;
        m_tvalid = 1'b0;
        m_tdata  = {DATA_W{1'b0}};
        m_tuser  = 1'b0;
        m_tlast  = 1'b0;
        if (ce_rst) begin
            s_tready = 1'b0;
        end else if (state_r == OUTPUT) begin
            s_tready = m_tready;
            m_tvalid = s_tvalid;
            m_tdata  = s_tdata;
            m_tuser  = (out_cnt_r == {LEN_W{1'b0}});
            m_tlast  = (out_cnt_r == pkt_last_r);
        end else begin
            s_tready = 1'b1;
        end
    end

    // Frame sequencer and detection status registers.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state_r    <= SEARCH;
            peak_val_r <= {METRIC_W{1'b0}};
            peak_idx_r <= {WIN_W{1'b0}};
            win_cnt_r  <= {WIN_W{1'b0}};
            skip_cnt_r <= {(LEN_W+1){1'b0}};
            out_cnt_r  <= {LEN_W{1'b0}};
            pkt_last_r <= {LEN_W{1'b0}};
            offset_r   <= {LEN_W{1'b0}};
            det_pulse  <= 1'b0;
            det_late   <= 1'b0;
            det_peak   <= {METRIC_W{1'b0}};
            det_count  <= 32'd0;
        end else begin
            det_pulse <= 1'b0;
            case (state_r)
                SEARCH: begin
                    if (accept_s && cfg_enable && (s_metric > cfg_threshold)) begin
                        state_r    <= PEAK;
                        pkt_last_r <= (cfg_packet_size == {LEN_W{1'b0}}) ? {LEN_W{1'b0}}
                                                                         : cfg_packet_size - LEN_W'(1'b1);
                        offset_r   <= cfg_offset;
                        peak_val_r <= s_metric;
                        peak_idx_r <= {WIN_W{1'b0}};
                        win_cnt_r  <= WIN_W'(1'b1);
                    end
                end
                PEAK: begin
                    if (accept_s) begin
                        peak_val_r <= peak_val_nxt_s;
                        peak_idx_r <= peak_idx_nxt_s;
                        win_cnt_r  <= win_cnt_r + WIN_W'(1'b1);
                        if (win_cnt_r == WIN_LAST) begin
                            det_pulse <= 1'b1;
                            det_count <= det_count + 32'd1;
                            det_peak  <= peak_val_nxt_s;
                            if (late_s) begin
                                det_late <= 1'b1;
                                state_r  <= OUTPUT;
                            end else begin
                                det_late <= 1'b0;
                                if (skip_s > ZERO_L) begin
                                    skip_cnt_r <= skip_s;
                                    state_r    <= SKIP;
                                end else begin
                                    state_r <= OUTPUT;
                                end
                            end
                        end
                    end
                end
                SKIP: begin
                    if (accept_s) begin
                        skip_cnt_r <= skip_cnt_r - (LEN_W+1)'(1'b1);
                        if (skip_cnt_r == (LEN_W+1)'(1'b1)) begin
                            state_r <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (accept_s) begin
                        if (out_cnt_r == pkt_last_r) begin
                            out_cnt_r <= {LEN_W{1'b0}};
                            state_r   <= SEARCH;
                        end else begin
                            out_cnt_r <= out_cnt_r + LEN_W'(1'b1);
                        end
                    end
                end
                default: state_r <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_schmidl_cox_frame_ctrl.sv
// Randomised bench for schmidl_cox_frame_ctrl: a beat-indexed reference model marks
// which input beats must appear on the output, and every cycle is checked against it.
module tb_schmidl_cox_frame_ctrl;

    localparam int          W     = 64;
    localparam int          MAXN  = 11000;
    localparam logic [31:0] THR   = 32'h0020_0000;
    localparam logic [31:0] STEP  = 32'h0001_0000;
    localparam logic [31:0] PK    = THR + 32'd11 * STEP;

    logic        clk;
    logic        ce_rst;
    logic        cfg_enable;
    logic [31:0] cfg_threshold;
    logic [15:0] cfg_packet_size;
    logic [15:0] cfg_offset;
    logic [31:0] s_tdata;
    logic [31:0] s_metric;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        det_pulse;
    logic        det_late;
    logic [31:0] det_peak;
    logic [31:0] det_count;

    schmidl_cox_frame_ctrl #(
        .DATA_W(32), .METRIC_W(32), .LEN_W(16), .PEAK_WIN(W)
    ) dut (
        .ce_clk(clk), .ce_rst(ce_rst), .cfg_enable(cfg_enable),
        .cfg_threshold(cfg_threshold), .cfg_packet_size(cfg_packet_size),
        .cfg_offset(cfg_offset), .s_tdata(s_tdata), .s_metric(s_metric),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .det_pulse(det_pulse), .det_late(det_late),
        .det_peak(det_peak), .det_count(det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] met [MAXN];
    logic [31:0] dat [MAXN];
    bit          eo  [MAXN];
    bit          eu  [MAXN];
    bit          el  [MAXN];
    bit          ed  [MAXN];

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_count = 0;
    logic        exp_late = 1'b0;
    logic [31:0] exp_peak = 32'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_noise(input int n, input bit zero);
        for (int k = 0; k < n; k++) begin
            met[k] = zero ? 32'd0 : 32'($urandom_range(0, 32'h0010_0000));
            dat[k] = $urandom;
        end
    endtask

    // Triangle peaking at c; the first beat above threshold is c-10.
    task automatic add_ramp(input int c);
        for (int k = -11; k <= 11; k++) begin
            met[c+k] = PK - STEP * 32'((k < 0) ? -k : k);
        end
    endtask

    task automatic add_plateau(input int a, input int b);
        for (int k = a; k <= b; k++) met[k] = PK;
    endtask

    // Reference: scan beats, pick first-occurrence argmax in the window, mark output beats.
    task automatic build_expect(input int n);
        int i, pk, last, d, start, len;
        logic [31:0] mx;
        for (int k = 0; k < n; k++) begin
            eo[k] = 1'b0; eu[k] = 1'b0; el[k] = 1'b0; ed[k] = 1'b0;
        end
        i = 0;
        while (i < n) begin
            if (cfg_enable && met[i] > cfg_threshold && i + W <= n) begin
                pk = i;
                mx = met[i];
                for (int k = i + 1; k < i + W; k++) begin
                    if (met[k] > mx) begin
                        mx = met[k];
                        pk = k;
                    end
                end
                last = i + W - 1;
                ed[last] = 1'b1;
                d = W - 1 - (pk - i);
                if (int'(cfg_offset) > d) begin
                    start = pk + int'(cfg_offset);
                    exp_late = 1'b0;
                end else begin
                    start = last + 1;
                    exp_late = 1'b1;
                end
                len = (cfg_packet_size == 16'd0) ? 1 : int'(cfg_packet_size);
                for (int k = 0; k < len; k++) begin
                    if (start + k < n) begin
                        eo[start+k] = 1'b1;
                        eu[start+k] = (k == 0);
                        el[start+k] = (k == len - 1);
                    end
                end
                exp_count++;
                exp_peak = mx;
                i = start + len;
            end else begin
                i++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        ce_rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 ce_rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic run_stream(input int n, input bit stall, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int outs = 0;
        bit acc;
        bit det_due = 1'b0;
        while (idx < n && cyc < n * 3 + 200) begin
            @(posedge clk); #1;
            cyc++;
            s_tdata  = dat[idx];
            s_metric = met[idx];
            if (abort_at >= 0 && outs == abort_at) begin
                ce_rst   = 1'b1;
                s_tvalid = 1'b1;
                m_tready = 1'b1;
                @(negedge clk);
                chk("rst_s_tready", 64'(s_tready), 64'(0));
                chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
                @(posedge clk); #1;
                ce_rst = 1'b0;
                @(negedge clk);
                chk("post_rst_m_tvalid", 64'(m_tvalid), 64'(0));
                chk("post_rst_flags", 64'({m_tuser, m_tlast, det_pulse, det_late}), 64'(0));
                chk("post_rst_m_tdata", 64'(m_tdata), 64'(0));
                chk("post_rst_det_peak", 64'(det_peak), 64'(0));
                chk("post_rst_det_count", 64'(det_count), 64'(0));
                exp_count = 0;
                return;
            end
            s_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            chk("det_pulse", 64'(det_pulse), 64'(det_due));
            if (eo[idx]) begin
                chk("out_m_tvalid", 64'(m_tvalid), 64'(s_tvalid));
                chk("out_s_tready", 64'(s_tready), 64'(m_tready));
                chk("out_m_tdata", 64'(m_tdata), 64'(dat[idx]));
                chk("out_m_tuser", 64'(m_tuser), 64'(eu[idx]));
                chk("out_m_tlast", 64'(m_tlast), 64'(el[idx]));
            end else begin
                chk("idle_m_tvalid", 64'(m_tvalid), 64'(0));
                chk("idle_s_tready", 64'(s_tready), 64'(1));
                chk("idle_m_tdata", 64'(m_tdata), 64'(0));
                chk("idle_flags", 64'({m_tuser, m_tlast}), 64'(0));
            end
            acc = s_tvalid && s_tready;
            det_due = acc && ed[idx];
            if (acc) begin
                if (eo[idx]) outs++;
                idx++;
            end
        end
        chk("stream_timeout", 64'(idx), 64'(n));
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        chk("det_pulse_tail", 64'(det_pulse), 64'(det_due));
        chk("det_count", 64'(det_count), 64'(exp_count));
        chk("det_late", 64'(det_late), 64'(exp_late));
        chk("det_peak", 64'(det_peak), 64'(exp_peak));
    endtask

    initial begin
        ce_rst          = 1'b1;
        cfg_enable      = 1'b1;
        cfg_threshold   = THR;
        cfg_packet_size = 16'd2304;
        cfg_offset      = 16'd100;
        s_tdata         = 32'd0;
        s_metric        = 32'd0;
        s_tvalid        = 1'b0;
        m_tready        = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_s_tready", 64'(s_tready), 64'(0));
        do_reset();
        @(negedge clk);
        chk("reset_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("reset_flags", 64'({m_tuser, m_tlast, det_pulse, det_late}), 64'(0));
        chk("reset_det_peak", 64'(det_peak), 64'(0));
        chk("reset_det_count", 64'(det_count), 64'(0));
        chk("reset_m_tdata", 64'(m_tdata), 64'(0));
        chk("reset_s_tready_after", 64'(s_tready), 64'(1));

        // Metric 0 everywhere: nothing detected
        fill_noise(2000, 1'b1);
        build_expect(2000);
        run_stream(2000, 1'b0, -1);

        // Ramp peaking at 1000, offset 100
        do_reset();
        fill_noise(3500, 1'b0);
        add_ramp(1000);
        build_expect(3500);
        run_stream(3500, 1'b0, -1);

        // Late offset: output right after the window
        do_reset();
        cfg_offset = 16'd10;
        build_expect(3500);
        run_stream(3500, 1'b0, -1);

        // Plateau of equal maxima: first occurrence wins
        do_reset();
        cfg_offset = 16'd100;
        fill_noise(3500, 1'b0);
        add_plateau(990, 1050);
        build_expect(3500);
        run_stream(3500, 1'b0, -1);

        // Two frames 5000 beats apart under random stalls on both sides
        do_reset();
        fill_noise(10900, 1'b0);
        add_ramp(1000);
        add_ramp(8414);
        build_expect(10900);
        run_stream(10900, 1'b1, -1);

        // Reset at output beat 500, then a normal re-detection
        do_reset();
        fill_noise(3500, 1'b0);
        add_ramp(1000);
        build_expect(3500);
        run_stream(3500, 1'b0, 500);
        fill_noise(3500, 1'b0);
        add_ramp(1000);
        build_expect(3500);
        run_stream(3500, 1'b1, -1);

        // Packet size 0 behaves as a single-beat packet
        do_reset();
        cfg_packet_size = 16'd0;
        fill_noise(700, 1'b0);
        add_ramp(500);
        build_expect(700);
        run_stream(700, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
